// File: rtl/queue.sv
// Synchronous FIFO queue with registered occupancy count, sticky overflow/underflow
// flags and a flush that takes priority over push/pop. All state moves on the falling edge.
module queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign data_out  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop on a full queue frees the slot, so a simultaneous push may still land.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (push && !do_push) ovf_d = 1'b1;
            if (pop && !do_pop)   udf_d = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is never reset; stale words are hidden because data_out is gated by empty.
    always_ff @(negedge clk) begin
        if (!rst && !flush && do_push) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the falling edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port push, input, 1, enqueue data_in at the tail.
REQ-006 SHALL have port pop, input, 1, dequeue the head entry.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-008 SHALL have port data_in, input, WIDTH, word to enqueue.
REQ-009 SHALL have port data_out, output, WIDTH, current head entry (oldest word).
REQ-010 SHALL have port full, output, 1, high when count == DEPTH.
REQ-011 SHALL have port empty, output, 1, high when count == 0.
REQ-012 SHALL have port count, output, log2(DEPTH)+1, number of stored entries.
REQ-013 SHALL have port overflow, output, 1, sticky flag: push rejected.
REQ-014 SHALL have port underflow, output, 1, sticky flag: pop rejected.

Function
REQ-015 SHALL store entries in a DEPTH x WIDTH memory addressed by wr_ptr and rd_ptr, each log2(DEPTH) bits wide, wrapping modulo DEPTH.
REQ-016 SHALL drive data_out combinationally as mem[rd_ptr] when empty is low, and as all-zeros when empty is high; zero latency from pointer update.
REQ-017 SHALL derive full, empty and count from a registered count, never from pointer equality alone.
REQ-018 Accepted push: write data_in to mem[wr_ptr], advance wr_ptr by 1.
REQ-019 Accepted pop: advance rd_ptr by 1; memory contents unchanged.
REQ-020 Push only, not full: accept it; count +1.
REQ-021 Push only, full: reject it; memory, pointers and count unchanged; set overflow.
REQ-022 Pop only, not empty: accept it; count -1.
REQ-023 Pop only, empty: reject it; state unchanged; set underflow.
REQ-024 Push and pop, neither full nor empty: accept both in the same edge; count unchanged.
REQ-025 Push and pop, empty: accept the push, reject the pop (no fall-through); count becomes 1; set underflow.
REQ-026 Push and pop, full: accept both (the pop frees the slot the push writes); count stays DEPTH; overflow not set.
REQ-027 flush SHALL take priority over push and pop: wr_ptr, rd_ptr and count go to 0; overflow and underflow are cleared; memory is not cleared.
REQ-028 Overflow and underflow SHALL remain set until rst or flush.
REQ-029 count SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-030 rst high at a falling clk edge SHALL set wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, overflow=0, underflow=0, and data_out=0.
REQ-031 rst SHALL take priority over flush, push and pop; memory contents are undefined after reset and never observable, because data_out is gated by empty.
REQ-032 rst asserted in the middle of a push/pop sequence SHALL discard all queued entries at that edge.
REQ-033 Before the first rst, outputs are don't-care; the bench SHALL apply rst first.

Verification
REQ-034 Reset, then push 0x0001, 0x0002, 0x0003, then pop three times -> data_out shows 0x0001, 0x0002, 0x0003 in order; empty=1 and data_out=0x0000 at the end.
REQ-035 Push 8 words 0x00A0..0x00A7 -> full=1, count=8; a 9th push of 0xFFFF -> overflow=1; pop all 8 -> 0x00A0..0x00A7 returned, no 0xFFFF.
REQ-036 Pop while empty, with push 0x1234 in the same cycle -> count=1, data_out=0x1234, underflow=1.
REQ-037 Full queue, push 0x5555 and pop in the same cycle -> count=8, full=1, overflow=0, head advances; after 8 pops the last word is 0x5555.
REQ-038 Wrap-around: 20 interleaved push/pop cycles holding count at 3 -> output order matches input order across pointer wrap.
REQ-039 Flush asserted together with push after overflow -> count=0, empty=1, overflow=0, underflow=0, pushed word discarded.
